// File: rtl/sqrt_fixed_point_pkg.sv
// Shared helpers for the pipelined fixed-point square root.
// SQRT_FIXED_POINT_ROUND_EN adds a round-to-nearest output stage.
package sqrt_fixed_point_pkg;

`ifdef SQRT_FIXED_POINT_ROUND_EN
  localparam int unsigned RoundStages = 1;
`else
  localparam int unsigned RoundStages = 0;
`endif

  // Default widths of the stage record below.
  localparam int unsigned DefOutWidth = 16;
  localparam int unsigned DefTagWidth = 2;

  function automatic int unsigned out_dec_width(input int unsigned in_w,
                                                input int unsigned in_dec_w,
                                                input int unsigned out_w);
    return out_w - (in_w - in_dec_w + 1) / 2;
  endfunction

  function automatic int unsigned padded_width(input int unsigned out_w);
    return 2 * out_w;
  endfunction

  // One leading zero keeps the whole part an even number of bits wide.
  function automatic int unsigned odd_pad(input int unsigned in_w, input int unsigned in_dec_w);
    return (in_w - in_dec_w) % 2;
  endfunction

  function automatic int unsigned pipe_latency(input int unsigned out_w,
                                               input int unsigned bits_per_stage);
    return out_w / bits_per_stage + RoundStages;
  endfunction

  // Field layout of one pipeline stage; the stage ports follow this order.
  typedef struct packed {
    logic                         valid;
    logic [DefTagWidth-1:0]       tag;
    logic [DefOutWidth-1:0]       q;
    logic [DefOutWidth:0]         rem;
    logic [2*DefOutWidth-1:0]     rad;
  } stage_rec_t;

endpackage

// File: rtl/sqrt_fixed_point_stage.sv
// One pipeline stage: BITS_PER_STAGE restoring root iterations followed by a
// register that holds its contents while advance_i is low.
module sqrt_fixed_point_stage
  import sqrt_fixed_point_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH      = 2,
  parameter int unsigned BITS_PER_STAGE = 1
) (
  input  logic                            clk,
  input  logic                            aclr,
  input  logic                            advance_i,
  input  logic                            valid_i,
  input  logic [TAG_WIDTH-1:0]            tag_i,
  input  logic [OUTPUT_WIDTH-1:0]         q_i,
  input  logic [OUTPUT_WIDTH:0]           rem_i,
  input  logic [2*OUTPUT_WIDTH-1:0]       rad_i,
  output logic                            valid_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic [OUTPUT_WIDTH-1:0]         q_o,
  output logic [OUTPUT_WIDTH:0]           rem_o,
  output logic [2*OUTPUT_WIDTH-1:0]       rad_o
);

  localparam int unsigned PadW  = padded_width(OUTPUT_WIDTH);
  localparam int unsigned RemW  = OUTPUT_WIDTH + 1;
  localparam int unsigned WideW = OUTPUT_WIDTH + 3;

  logic                    valid_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [OUTPUT_WIDTH-1:0] q_d, q_q;
  logic [RemW-1:0]         rem_d, rem_q;
  logic [PadW-1:0]         rad_d, rad_q;
  logic [WideW-1:0]        shifted, sub;
  logic                    ge;

  always_comb begin
    q_d     = q_i;
    rem_d   = rem_i;
    rad_d   = rad_i;
    shifted = '0;
    sub     = '0;
    ge      = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
      shifted = {rem_d, rad_d[PadW-1 -: 2]};
      sub     = {1'b0, q_d, 2'b01};
      ge      = (shifted >= sub);
      // Stored remainder never exceeds 2*q, so RemW bits always suffice.
      rem_d   = ge ? RemW'(shifted - sub) : RemW'(shifted);
      q_d     = (q_d << 1) | OUTPUT_WIDTH'(ge);
      rad_d   = rad_d << 2;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      rad_q   <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      tag_q   <= tag_i;
      q_q     <= q_d;
      rem_q   <= rem_d;
      rad_q   <= rad_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign q_o     = q_q;
  assign rem_o   = rem_q;
  assign rad_o   = rad_q;

endmodule

// File: rtl/sqrt_fixed_point_pipe.sv
// Fully pipelined fixed-point square root with valid/ready flow control.
// Define SQRT_FIXED_POINT_ROUND_EN for a rounded root and one extra stage.
module sqrt_fixed_point_pipe
  import sqrt_fixed_point_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH     = 16,
  parameter int unsigned INPUT_DEC_WIDTH = 8,
  parameter int unsigned OUTPUT_WIDTH    = 16,
  parameter int unsigned TAG_WIDTH       = 2,
  parameter int unsigned BITS_PER_STAGE  = 1
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_WIDTH-1:0]     radical,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic [OUTPUT_WIDTH-1:0]    q,
  output logic [OUTPUT_WIDTH:0]      remainder,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned S        = OUTPUT_WIDTH / BITS_PER_STAGE;
  localparam int unsigned PadW     = padded_width(OUTPUT_WIDTH);
  localparam int unsigned Odd      = odd_pad(INPUT_WIDTH, INPUT_DEC_WIDTH);
  localparam int unsigned PadShift =
      (INPUT_WIDTH + Odd > PadW) ? 0 : PadW - INPUT_WIDTH - Odd;

  if (INPUT_WIDTH + Odd > PadW) begin : g_err_pad
    $error("padded radical does not fit in 2*OUTPUT_WIDTH bits");
  end
  if (INPUT_DEC_WIDTH > INPUT_WIDTH) begin : g_err_dec
    $error("INPUT_DEC_WIDTH exceeds INPUT_WIDTH");
  end
  if (!(BITS_PER_STAGE inside {1, 2, 4}) || (OUTPUT_WIDTH % BITS_PER_STAGE) != 0) begin : g_err_bps
    $error("BITS_PER_STAGE must be 1, 2 or 4 and divide OUTPUT_WIDTH");
  end
  if (TAG_WIDTH < 1) begin : g_err_tag
    $error("TAG_WIDTH must be at least 1");
  end

  logic                              advance;
  logic [S:0]                        valid_s;
  logic [S:0][TAG_WIDTH-1:0]         tag_s;
  logic [S:0][OUTPUT_WIDTH-1:0]      q_s;
  logic [S:0][OUTPUT_WIDTH:0]        rem_s;
  logic [S:0][PadW-1:0]              rad_s;

  // Leading odd-pad zero falls out of the widening; trailing zeros from the shift.
  assign valid_s[0] = in_valid;
  assign tag_s[0]   = in_tag;
  assign q_s[0]     = '0;
  assign rem_s[0]   = '0;
  assign rad_s[0]   = PadW'(radical) << PadShift;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar g = 0; g < S; g++) begin : g_stage
    sqrt_fixed_point_stage #(
      .OUTPUT_WIDTH  (OUTPUT_WIDTH),
      .TAG_WIDTH     (TAG_WIDTH),
      .BITS_PER_STAGE(BITS_PER_STAGE)
    ) u_stage (
      .clk      (clk),
      .aclr     (aclr),
      .advance_i(advance),
      .valid_i  (valid_s[g]),
      .tag_i    (tag_s[g]),
      .q_i      (q_s[g]),
      .rem_i    (rem_s[g]),
      .rad_i    (rad_s[g]),
      .valid_o  (valid_s[g+1]),
      .tag_o    (tag_s[g+1]),
      .q_o      (q_s[g+1]),
      .rem_o    (rem_s[g+1]),
      .rad_o    (rad_s[g+1])
    );
  end

`ifdef SQRT_FIXED_POINT_ROUND_EN
  logic                    rnd_valid_q;
  logic [TAG_WIDTH-1:0]    rnd_tag_q;
  logic [OUTPUT_WIDTH-1:0] rnd_q_d, rnd_q_q;
  logic [OUTPUT_WIDTH:0]   rnd_rem_q;

  // Round up when rem exceeds q, i.e. the true root is past q + 0.5.
  always_comb begin
    rnd_q_d = q_s[S];
    if ((rem_s[S] > {1'b0, q_s[S]}) && (q_s[S] != '1)) begin
      rnd_q_d = q_s[S] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rnd_valid_q <= 1'b0;
      rnd_tag_q   <= '0;
      rnd_q_q     <= '0;
      rnd_rem_q   <= '0;
    end else if (advance) begin
      rnd_valid_q <= valid_s[S];
      rnd_tag_q   <= tag_s[S];
      rnd_q_q     <= rnd_q_d;
      rnd_rem_q   <= rem_s[S];
    end
  end

  assign out_valid = rnd_valid_q;
  assign out_tag   = rnd_tag_q;
  assign q         = rnd_q_q;
  assign remainder = rnd_rem_q;
`else
  assign out_valid = valid_s[S];
  assign out_tag   = tag_s[S];
  assign q         = q_s[S];
  assign remainder = rem_s[S];
`endif

endmodule
